// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : RV32I instruction-fetch stage with one-deep request tracking,
//              wrong-path response drop and a one-entry IF/ID skid buffer.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_id,
  input  logic        flush_id,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  input  logic        jump_id_stage,
  input  logic [31:0] jump_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;

  logic        redirect;
  logic [31:0] target;
  logic        req_fire;
  logic        rsp_take;

  // EX redirect is older than the ID jump, so it wins.
  assign redirect = pc_src | jump_id_stage;
  assign target   = (pc_src ? branch_target : jump_target) & ALIGN_MASK;

  assign imem_req_valid = rst_n && (state_q == ST_REQ) && !hold_valid_q;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    rsp_take      = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (req_fire) begin
          if (redirect) begin
            pc_d    = target;
            state_d = ST_DROP;
          end else begin
            inflight_pc_d = pc_q;
            pc_d          = pc_q + 32'd4;
            state_d       = ST_WAIT;
          end
        end else if (redirect) begin
          pc_d = target;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (imem_rsp_valid) begin
          rsp_take = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect) pc_d = target;
        if (imem_rsp_valid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_pc_d     = hold_pc_q;
    hold_instr_d  = hold_instr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if (flush_id) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
      hold_valid_d  = 1'b0;
    end else if (stall_id) begin
      if (rsp_take) begin
        hold_valid_d = 1'b1;
        hold_pc_d    = inflight_pc_q;
        hold_instr_d = imem_rsp_data;
      end
    end else if (hold_valid_q) begin
      if_id_valid_d = 1'b1;
      if_id_pc_d    = hold_pc_q;
      if_id_instr_d = hold_instr_q;
      hold_valid_d  = 1'b0;
    end else if (rsp_take) begin
      if_id_valid_d = 1'b1;
      if_id_pc_d    = inflight_pc_q;
      if_id_instr_d = imem_rsp_data;
    end else begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
    end
    // A held word is wrong-path once the PC has been redirected.
    if (redirect) hold_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC & ALIGN_MASK;
      inflight_pc_q <= 32'd0;
      hold_valid_q  <= 1'b0;
      hold_pc_q     <= 32'd0;
      hold_instr_q  <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      hold_valid_q  <= hold_valid_d;
      hold_pc_q     <= hold_pc_d;
      hold_instr_q  <= hold_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

  assign if_id_valid    = if_id_valid_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc_q + 32'd4;
  assign if_id_instr    = if_id_instr_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed-vector bench for fetch_unit with a simple
//                 programmable-latency instruction memory.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_id, flush_id, pc_src, jump_id_stage;
  logic [31:0] branch_target, jump_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;

  int n_vec = 0;
  int n_err = 0;

  // memory model state
  int          mem_lat = 1;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_id       (stall_id),
    .flush_id       (flush_id),
    .pc_src         (pc_src),
    .branch_target  (branch_target),
    .jump_id_stage  (jump_id_stage),
    .jump_target    (jump_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr);
    check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    if (v) begin
      check_eq({tag, ".pc"}, if_id_pc, pc);
      check_eq({tag, ".pc4"}, if_id_pc_plus4, pc + 32'd4);
    end
    check_eq({tag, ".instr"}, if_id_instr, instr);
  endtask

  task automatic check_req(input string tag, input logic v, input logic [31:0] addr);
    check_eq({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, v});
    if (v) check_eq({tag, ".req_addr"}, imem_req_addr, addr);
  endtask

  // One clock: note acceptance before the edge, then update the memory model.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    if (acc) begin
      pend      = 1'b1;
      pend_cnt  = mem_lat;
      pend_addr = a;
    end
    if (pend && pend_cnt == 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(pend_addr);
      pend           = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      if (pend) pend_cnt--;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stall_id = 0; flush_id = 0; pc_src = 0; jump_id_stage = 0;
    branch_target = 0; jump_target = 0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 0;
    pend = 1'b0; pend_cnt = 0; pend_addr = 0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    check_ifid("rst", 1'b0, 32'd0, NOP);
    check_eq("rst.pc", if_id_pc, 32'd0);
    check_eq("rst.pc4", if_id_pc_plus4, 32'd4);
    check_req("rst", 1'b0, 32'd0);

    rst_n = 1'b1; #1;
    check_req("first", 1'b1, 32'h100);

    // streaming with a 1-cycle memory
    cycle(); check_req("s1", 1'b0, 0);
    cycle(); check_ifid("s2", 1'b1, 32'h100, word_at(32'h100)); check_req("s2", 1'b1, 32'h104);
    cycle(); check_ifid("s3", 1'b0, 0, NOP);
    cycle(); check_ifid("s4", 1'b1, 32'h104, word_at(32'h104));
    cycle(); check_ifid("s5", 1'b0, 0, NOP);
    cycle(); check_ifid("s6", 1'b1, 32'h108, word_at(32'h108)); check_req("s6", 1'b1, 32'h10C);

    // stall for 3 edges while the response for 0x10C arrives
    stall_id = 1'b1;
    cycle(); check_ifid("st1", 1'b1, 32'h108, word_at(32'h108));
    cycle(); check_ifid("st2", 1'b1, 32'h108, word_at(32'h108)); check_req("st2", 1'b0, 0);
    cycle(); check_ifid("st3", 1'b1, 32'h108, word_at(32'h108)); check_req("st3", 1'b0, 0);
    stall_id = 1'b0;
    cycle(); check_ifid("st4", 1'b1, 32'h10C, word_at(32'h10C)); check_req("st4", 1'b1, 32'h110);

    // EX redirect while waiting, response two cycles after acceptance
    mem_lat = 2;
    cycle(); check_req("br0", 1'b0, 0);
    pc_src = 1'b1; branch_target = 32'h200;
    cycle(); pc_src = 1'b0;
    check_ifid("br1", 1'b0, 0, NOP); check_req("br1", 1'b0, 0);
    cycle(); check_ifid("br2", 1'b0, 0, NOP); check_req("br2", 1'b1, 32'h200);
    mem_lat = 1;

    // ID jump coincident with a response, unaligned target
    cycle();
    jump_id_stage = 1'b1; jump_target = 32'h302;
    cycle(); jump_id_stage = 1'b0;
    check_ifid("jmp", 1'b0, 0, NOP); check_req("jmp", 1'b1, 32'h300);

    // simultaneous redirects while the request is not accepted
    imem_req_ready = 1'b0;
    pc_src = 1'b1; branch_target = 32'h400; jump_id_stage = 1'b1; jump_target = 32'h500;
    cycle(); pc_src = 1'b0; jump_id_stage = 1'b0;
    check_req("both", 1'b1, 32'h400);
    cycle(); check_req("noacc", 1'b1, 32'h400);
    imem_req_ready = 1'b1;

    // fill the hold buffer, then flush with stall still high
    stall_id = 1'b1;
    cycle();
    cycle(); check_req("hfull", 1'b0, 0);
    flush_id = 1'b1;
    cycle(); flush_id = 1'b0; stall_id = 1'b0;
    check_ifid("fl", 1'b0, 0, NOP); check_req("fl", 1'b1, 32'h404);
    cycle(); check_ifid("fl1", 1'b0, 0, NOP);
    cycle(); check_ifid("fl2", 1'b1, 32'h404, word_at(32'h404));

    // asynchronous reset mid-operation
    #2; rst_n = 1'b0; #1;
    pend = 1'b0; imem_rsp_valid = 1'b0;
    check_ifid("arst", 1'b0, 0, NOP); check_req("arst", 1'b0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    check_req("arst.rel", 1'b1, 32'h100);
    cycle();
    cycle(); check_ifid("arst.f", 1'b1, 32'h100, word_at(32'h100));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage RV32I pipeline. It sits directly upstream of the IF/ID boundary and consumes the HazardUnit outputs `stall_id` and `flush_id`, plus the EX-stage redirect (`pc_src`) and the ID-stage JAL redirect (`jump_id_stage`). It owns the PC and a valid/ready instruction-memory port with at most one request in flight. It discards wrong-path responses after a redirect and holds one instruction while ID is stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): instruction driven on bubbles.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall_id` in 1: hold the IF/ID outputs (HazardUnit load-use stall).
- `flush_id` in 1: kill the IF/ID contents (HazardUnit control-hazard flush).
- `pc_src` in 1: taken branch or JALR resolved in EX.
- `branch_target` in 32: EX redirect address.
- `jump_id_stage` in 1: JAL decoded in ID.
- `jump_target` in 32: ID redirect address.
- `imem_req_valid` out 1: fetch request.
- `imem_req_addr` out 32: fetch address; always word-aligned.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_rsp_valid` in 1: instruction word returned.
- `imem_rsp_data` in 32: instruction word.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_pc` out 32: PC of that instruction.
- `if_id_pc_plus4` out 32: `if_id_pc + 4`.
- `if_id_instr` out 32: instruction, or `NOP_INSTR` when invalid.

## Operation
- Internal state:
  - `pc`: next address to request.
  - `inflight_pc`: address of the outstanding request.
  - `hold_valid`, `hold_pc`, `hold_instr`: one-entry skid buffer.
  - FSM: REQ, WAIT, DROP.
- Redirect:
  - `redirect = pc_src | jump_id_stage`.
  - Target is `branch_target` if `pc_src` is high (EX is older, so it has priority), else `jump_target`.
  - Target bits [1:0] are forced to 0.
- REQ state:
  - `imem_req_valid = !hold_valid` (forced 0 while `rst_n` is low); `imem_req_addr = pc`.
  - On acceptance (`valid & ready`) with no redirect: `inflight_pc <= pc`, `pc <= pc + 4` (mod 2^32), go to WAIT.
  - On acceptance in the same cycle as a redirect: the accepted request is wrong-path. Set `pc <= target` and go to DROP.
  - On redirect without acceptance: `pc <= target`, stay in REQ. Address may change while valid is high only in this case; otherwise valid and address stay stable until accepted.
- WAIT state:
  - `imem_req_valid = 0`.
  - On `imem_rsp_valid` with no redirect: the response is captured (see IF/ID rules), go to REQ.
  - On redirect with `imem_rsp_valid`: discard the response, `pc <= target`, go to REQ.
  - On redirect without a response: `pc <= target`, go to DROP.
- DROP state:
  - `imem_req_valid = 0`.
  - The next `imem_rsp_valid` is discarded; go to REQ.
  - A redirect while in DROP updates `pc` and stays in DROP.
- `imem_rsp_valid` outside WAIT/DROP is a protocol violation and is ignored.
- IF/ID update, in priority order:
  1. `flush_id`: `if_id_valid <= 0`, `if_id_instr <= NOP_INSTR`, and `hold_valid <= 0`. Any response captured this cycle is discarded. Overrides `stall_id`.
  2. `stall_id`: IF/ID outputs unchanged. A valid, non-discarded response is written to the hold buffer.
  3. Otherwise, in order:
     - If `hold_valid`: load IF/ID from the hold buffer and clear `hold_valid`.
     - Else if a valid, non-discarded response arrives: load `{inflight_pc, imem_rsp_data}`.
     - Else: bubble (`if_id_valid <= 0`, instr = `NOP_INSTR`).
- A redirect also clears `hold_valid` (the held word is wrong-path).
- `hold_valid` blocks new requests, so a response never arrives while the buffer is full.

## Timing
- Reset (asynchronous, immediate):
  - `pc = RESET_PC`, state REQ, `hold_valid = 0`.
  - `if_id_valid = 0`, `if_id_pc = 0`, `if_id_pc_plus4 = 4`, `if_id_instr = NOP_INSTR`.
  - `imem_req_valid = 0`.
- First request is presented in the first cycle after `rst_n` rises, with address `RESET_PC`.
- Reset mid-operation abandons any in-flight request. The memory shares `rst_n` and drops it too.
- Memory response arrives no earlier than the cycle after acceptance.
- Latency from response to IF/ID outputs: 1 edge.
- Peak throughput: one instruction per 2 cycles with a 1-cycle memory.
- A redirect in cycle N puts the target on `imem_req_addr` in cycle N+1 if the FSM returns to REQ. From DROP, the target is presented the cycle after the stale response.

## Test plan
- Reset with `RESET_PC = 0x100`; 1-cycle memory, ready always high → IF/ID shows pc 0x100, 0x104, 0x108 on alternate cycles, bubbles in between, `pc_plus4` correct.
- Response for 0x104 arrives while `stall_id` is high for 3 cycles → IF/ID holds 0x100; no new request is issued. After the stall releases, 0x104 appears next cycle, then the fetch of 0x108 starts.
- `pc_src = 1`, `branch_target = 0x200` while in WAIT, response two cycles later → that response is dropped and never reaches IF/ID; the next request address is 0x200.
- `jump_id_stage = 1`, `jump_target = 0x302` in the same cycle as a response arrives → the response is discarded; the next request address is 0x300.
- `pc_src` and `jump_id_stage` asserted together (targets 0x400 and 0x500) → the next request address is 0x400.
- `flush_id` and `stall_id` high with the hold buffer full → `if_id_valid = 0`, hold buffer empty, and requests resume.
